// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, access sizes,
// requester identities and the alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_READ_WAIT  = 2'b01,
    ST_WRITE_WAIT = 2'b10
  } state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_LOAD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Loads and fetches are word accesses, so they share the word rule.
  function automatic logic access_aligned(input logic [1:0] addr_lo,
                                          input logic [1:0] size);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      default:   ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin selector; req_a is fetch,
// req_b is data, and a tie goes to whoever did not win last time.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t pick
);

  always_comb begin
    valid = req_a | req_b;
    pick  = OWNER_FETCH;
    if (req_a && req_b) begin
      pick = (last_owner == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end else if (req_b) begin
      pick = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store data,
// with round-robin grants, alignment rejection and registered outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_SIZE-1:0]  if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_size,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_write,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_done
);

  localparam logic [7:0] RD_INIT  = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LIMIT = 8'(WRITE_TIMEOUT);

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  owner_t                owner, owner_nxt;
  owner_t                last_owner, last_nxt;
  logic                  pick_valid;
  owner_t                pick;

  logic                  if_gnt_nxt, if_rvalid_nxt, if_err_nxt;
  logic                  d_gnt_nxt, d_rvalid_nxt, d_err_nxt;
  logic [WORD_SIZE-1:0]  if_rdata_nxt, d_rdata_nxt, mem_wdata_nxt;
  logic [ADDR_WIDTH-1:0] mem_address_nxt, win_addr;
  logic [1:0]            mem_write_nxt, win_size;
  logic                  win_store;

  rr_pick2 u_pick (
    .req_a      (if_req),
    .req_b      (d_req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      owner       <= OWNER_DATA;
      last_owner  <= OWNER_DATA;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      if_err      <= 1'b0;
      d_gnt       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
      mem_address <= '0;
      mem_write   <= 2'b00;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_nxt;
      if_gnt      <= if_gnt_nxt;
      if_rvalid   <= if_rvalid_nxt;
      if_rdata    <= if_rdata_nxt;
      if_err      <= if_err_nxt;
      d_gnt       <= d_gnt_nxt;
      d_rvalid    <= d_rvalid_nxt;
      d_rdata     <= d_rdata_nxt;
      d_err       <= d_err_nxt;
      mem_address <= mem_address_nxt;
      mem_write   <= mem_write_nxt;
      mem_wdata   <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    owner_nxt       = owner;
    last_nxt        = last_owner;
    if_gnt_nxt      = 1'b0;
    if_rvalid_nxt   = 1'b0;
    if_err_nxt      = 1'b0;
    d_gnt_nxt       = 1'b0;
    d_rvalid_nxt    = 1'b0;
    d_err_nxt       = 1'b0;
    if_rdata_nxt    = if_rdata;
    d_rdata_nxt     = d_rdata;
    mem_address_nxt = mem_address;
    mem_write_nxt   = mem_write;
    mem_wdata_nxt   = mem_wdata;

    win_addr  = (pick == OWNER_FETCH) ? if_addr : d_addr;
    win_size  = (pick == OWNER_FETCH) ? SIZE_LOAD : d_size;
    win_store = (pick == OWNER_DATA) && (d_size != SIZE_LOAD);

    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          last_nxt = pick;
          if (pick == OWNER_FETCH) if_gnt_nxt = 1'b1;
          else                     d_gnt_nxt  = 1'b1;
          // A misaligned winner is answered here and never reaches memory.
          if (!access_aligned(win_addr[1:0], win_size)) begin
            if (pick == OWNER_FETCH) if_err_nxt = 1'b1;
            else                     d_err_nxt  = 1'b1;
          end else begin
            owner_nxt       = pick;
            mem_address_nxt = win_addr;
            if (win_store) begin
              mem_write_nxt = d_size;
              mem_wdata_nxt = d_wdata;
              cnt_nxt       = '0;
              state_nxt     = ST_WRITE_WAIT;
            end else begin
              mem_write_nxt = 2'b00;
              cnt_nxt       = RD_INIT;
              state_nxt     = ST_READ_WAIT;
            end
          end
        end
      end

      ST_READ_WAIT: begin
        if (cnt == 8'd0) begin
          if (owner == OWNER_FETCH) begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = mem_rdata;
          end else begin
            d_rvalid_nxt = 1'b1;
            d_rdata_nxt  = mem_rdata;
          end
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      ST_WRITE_WAIT: begin
        if (mem_done) begin
          mem_write_nxt = 2'b00;
          d_rvalid_nxt  = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (cnt == WR_LIMIT) begin
          mem_write_nxt = 2'b00;
          d_err_nxt     = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are
// checked on the falling clock edge, with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int WS = 32;
  localparam int AW = 32;
  localparam int RL = 2;
  localparam int WT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_err;
  logic [WS-1:0] if_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [1:0]    d_size;
  logic [WS-1:0] d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [WS-1:0] d_rdata;
  logic [AW-1:0] mem_address;
  logic [1:0]    mem_write;
  logic [WS-1:0] mem_wdata;
  logic [WS-1:0] mem_rdata;
  logic          mem_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_TIMEOUT(WT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [31:0] daddr,
                               input logic [1:0] dsize, input logic [31:0] dwdata);
    if_req  = ireq;
    if_addr = iaddr;
    d_req   = dreq;
    d_addr  = daddr;
    d_size  = dsize;
    d_wdata = dwdata;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    mem_rdata = '0;
    mem_done  = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("rst_gnt",     {30'b0, if_gnt, d_gnt}, 32'h0);
    checkOutput("rst_pulses",  {28'b0, if_rvalid, if_err, d_rvalid, d_err}, 32'h0);
    checkOutput("rst_addr",    mem_address, 32'h0);
    checkOutput("rst_write",   {30'b0, mem_write}, 32'h0);
    checkOutput("rst_wdata",   mem_wdata, 32'h0);
    checkOutput("rst_rdata",   if_rdata | d_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Simultaneous requests right after reset: fetch wins, data follows.
    mem_rdata = 32'h1111_2222;
    applyStimulus(1'b1, 32'h8, 1'b1, 32'h100, 2'b00, 32'h0);
    tick();
    checkOutput("t2_if_gnt",   if_gnt, 1'b1);
    checkOutput("t2_d_gnt0",   d_gnt, 1'b0);
    checkOutput("t2_addr_if",  mem_address, 32'h8);
    if_req = 1'b0;
    tick();
    checkOutput("t2_no_rv",    {30'b0, if_rvalid, d_gnt}, 32'h0);
    tick();
    checkOutput("t2_if_rv",    if_rvalid, 1'b1);
    checkOutput("t2_if_rdata", if_rdata, 32'h1111_2222);
    checkOutput("t2_d_rv0",    d_rvalid, 1'b0);
    mem_rdata = 32'h3333_4444;
    tick();
    checkOutput("t2_d_gnt",    d_gnt, 1'b1);
    checkOutput("t2_if_gnt0",  {30'b0, if_gnt, if_rvalid}, 32'h0);
    checkOutput("t2_addr_d",   mem_address, 32'h100);
    d_req = 1'b0;
    tick();
    tick();
    checkOutput("t2_d_rv",     d_rvalid, 1'b1);
    checkOutput("t2_d_rdata",  d_rdata, 32'h3333_4444);
    checkOutput("t2_if_rv0",   if_rvalid, 1'b0);

    // Lone fetch.
    mem_rdata = 32'h0050_0093;
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 2'b00, 32'h0);
    tick();
    checkOutput("t1_gnt",      if_gnt, 1'b1);
    checkOutput("t1_addr",     mem_address, 32'h40);
    checkOutput("t1_write",    {30'b0, mem_write}, 32'h0);
    if_req = 1'b0;
    tick();
    checkOutput("t1_early_rv", if_rvalid, 1'b1 ^ 1'b1);
    tick();
    checkOutput("t1_rv",       if_rvalid, 1'b1);
    checkOutput("t1_rdata",    if_rdata, 32'h0050_0093);
    checkOutput("t1_d_quiet",  {29'b0, d_gnt, d_rvalid, d_err}, 32'h0);
    tick();
    checkOutput("t1_rv_pulse", if_rvalid, 1'b0);

    // Store half, mem_done arrives 3 cycles after the grant.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h22, 2'b10, 32'h0000_BEEF);
    tick();
    checkOutput("t3_gnt",      d_gnt, 1'b1);
    checkOutput("t3_write",    {30'b0, mem_write}, 32'h2);
    checkOutput("t3_addr",     mem_address, 32'h22);
    checkOutput("t3_wdata",    mem_wdata, 32'h0000_BEEF);
    d_req = 1'b0;
    tick();
    checkOutput("t3_hold1",    {30'b0, mem_write}, 32'h2);
    tick();
    checkOutput("t3_hold2",    {30'b0, mem_write}, 32'h2);
    tick();
    checkOutput("t3_hold3",    {29'b0, d_rvalid, mem_write}, 32'h2);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checkOutput("t3_rv",       d_rvalid, 1'b1);
    checkOutput("t3_wr_off",   {30'b0, mem_write}, 32'h0);
    checkOutput("t3_rdata",    d_rdata, 32'h3333_4444);
    tick();
    checkOutput("t3_rv_pulse", d_rvalid, 1'b0);

    // Misaligned word store and misaligned fetch; fetch wins the tie.
    applyStimulus(1'b1, 32'h6, 1'b1, 32'h13, 2'b11, 32'h1234_5678);
    tick();
    checkOutput("t4_if_ge",    {30'b0, if_gnt, if_err}, 32'h3);
    checkOutput("t4_d_idle",   {30'b0, d_gnt, d_err}, 32'h0);
    checkOutput("t4_write1",   {30'b0, mem_write}, 32'h0);
    checkOutput("t4_addr1",    mem_address, 32'h22);
    if_req = 1'b0;
    tick();
    checkOutput("t4_d_ge",     {30'b0, d_gnt, d_err}, 32'h3);
    checkOutput("t4_if_idle",  {30'b0, if_gnt, if_err}, 32'h0);
    checkOutput("t4_addr2",    mem_address, 32'h22);
    checkOutput("t4_write2",   {30'b0, mem_write}, 32'h0);
    d_req = 1'b0;
    tick();
    checkOutput("t4_quiet",    {28'b0, d_err, d_rvalid, if_rvalid, d_gnt}, 32'h0);

    // Store word that never completes: abort after the timeout.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 2'b11, 32'hCAFE_F00D);
    tick();
    checkOutput("t5_gnt",      d_gnt, 1'b1);
    checkOutput("t5_write",    {30'b0, mem_write}, 32'h3);
    d_req = 1'b0;
    for (int k = 1; k <= WT; k++) begin
      tick();
      checkOutput("t5_no_err", {30'b0, d_err, d_rvalid}, 32'h0);
    end
    checkOutput("t5_held",     {30'b0, mem_write}, 32'h3);
    tick();
    checkOutput("t5_err",      d_err, 1'b1);
    checkOutput("t5_wr_off",   {30'b0, mem_write}, 32'h0);
    checkOutput("t5_no_rv",    d_rvalid, 1'b0);

    // Back in IDLE: a fetch is granted on the next cycle, then reset hits.
    mem_rdata = 32'hDEAD_0001;
    applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 2'b00, 32'h0);
    tick();
    checkOutput("t5_idle_gnt", if_gnt, 1'b1);
    checkOutput("t6_addr",     mem_address, 32'h80);
    if_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_gnt",  if_gnt, 1'b0);
    checkOutput("t6_async_addr", mem_address, 32'h0);
    checkOutput("t6_async_wd",   mem_wdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t6_no_rv", {30'b0, if_rvalid, if_gnt}, 32'h0);
    end
    mem_rdata = 32'h0000_55AA;
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 2'b00, 32'h0);
    tick();
    checkOutput("t6_gnt",      if_gnt, 1'b1);
    checkOutput("t6_addr2",    mem_address, 32'h10);
    if_req = 1'b0;
    tick();
    tick();
    checkOutput("t6_rv",       if_rvalid, 1'b1);
    checkOutput("t6_rdata",    if_rdata, 32'h0000_55AA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single byte_addressable memory port between the instruction-fetch requester and the load/store data requester of the multi-cycle core.
- Grants one request at a time, using 2-way round-robin priority.
- Drives the memory address, write-size and write-data lines.
- Waits out the fixed read latency or the write-completion handshake, then returns a one-cycle response pulse to the owner.
- Rejects misaligned accesses locally, without touching memory.

Parameters:
WORD_SIZE, 32, data width in bits.
ADDR_WIDTH, 32, address width in bits.
READ_LATENCY, 2, cycles from mem_address valid to mem_rdata valid (range 1..7).
WRITE_TIMEOUT, 15, maximum cycles to wait for mem_done before aborting a write (range 1..255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_WIDTH  fetch address, word access
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle fetch-data-valid pulse
if_rdata  out  WORD_SIZE  fetch data, valid with if_rvalid
if_err  out  1  one-cycle misaligned-fetch pulse
d_req  in  1  data request; held with d_addr/d_size/d_wdata until d_gnt
d_addr  in  ADDR_WIDTH  data address
d_size  in  2  00 load word, 01 store byte, 10 store half, 11 store word
d_wdata  in  WORD_SIZE  store data
d_gnt  out  1  one-cycle grant pulse to data
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  WORD_SIZE  load data, valid with d_rvalid
d_err  out  1  one-cycle pulse: misaligned access or write timeout
mem_address  out  ADDR_WIDTH  memory address
mem_write  out  2  memory write size, 0 = read
mem_wdata  out  WORD_SIZE  memory write data
mem_rdata  in  WORD_SIZE  memory read data
mem_done  in  1  write-complete indication from memory

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - rst=1 asynchronously forces state IDLE, every output to 0 and last_owner to DATA.
  - rst mid-operation drops the in-flight access; no response pulse is issued afterwards, and mem_write is 0 immediately.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE arbitration (req sampled at edge E):
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_owner wins, then last_owner updates.
  - Neither high: stay in IDLE.
- Alignment check, performed on the winner before any memory access:
  - Word (fetch, load, size 11) requires addr[1:0]==0.
  - Half (size 10) requires addr[0]==0.
  - Byte (size 01) is always aligned.
- Misaligned winner:
  - gnt and err pulse together in cycle E+1.
  - mem_* are untouched; state stays IDLE.
- Aligned read (fetch, or d_size 00):
  - In cycle E+1, gnt pulses, mem_address=addr and mem_write=0; enter READ_WAIT with counter=READ_LATENCY-1.
  - When the counter reaches 0, capture mem_rdata.
  - rvalid and rdata appear in cycle E+1+READ_LATENCY; return to IDLE in that same cycle.
- Aligned store:
  - In cycle E+1, gnt pulses, mem_address=addr, mem_wdata=d_wdata and mem_write=d_size; enter WRITE_WAIT with timeout counter=0.
  - mem_write is held until mem_done is sampled high, then drops to 0 in the cycle where d_rvalid pulses; d_rdata is unchanged.
  - If the counter reaches WRITE_TIMEOUT with no mem_done, d_err pulses, mem_write goes to 0 and state returns to IDLE.
- Back-to-back: a request can be sampled at the edge that ends the response cycle. The minimum grant-to-grant spacing is READ_LATENCY+1 cycles for reads and 2 cycles for stores.
- Stability:
  - mem_address and mem_wdata hold their last value while in IDLE.
  - A requester may drop req only after it sees its gnt.
  - A requester must not raise a new req until its rvalid or err pulse.
- Pulse exclusivity: if_gnt and d_gnt are never high together. Each granted request gets exactly one rvalid or err pulse.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE/READ_WAIT/WRITE_WAIT);
  - size encodings SIZE_LOAD=2'b00, SIZE_BYTE=2'b01, SIZE_HALF=2'b10, SIZE_WORD=2'b11;
  - owner encoding OWNER_FETCH/OWNER_DATA.
- One sub-module, rr_pick2: a combinational 2-requester round-robin selector.
  - Inputs: req_a, req_b, last_owner.
  - Outputs: valid, pick.
- Alignment check and FSM stay in mem_port_arbiter.

Test Plan:
1. Fetch only, if_addr=0x40, mem_rdata=0x00500093: if_gnt at E+1, mem_address=0x40, mem_write=0; if_rvalid with if_rdata=0x00500093 at E+3; d_* stay 0.
2. Both requesters rise at the same edge after reset (last_owner=DATA), if_addr=0x8 and d_addr=0x100 load: fetch granted first; data granted at E+4; responses go to the correct ports with no overlap.
3. Store half at d_addr=0x22, d_wdata=0xBEEF, mem_done high 3 cycles after grant: mem_write=2'b10 held until mem_done is sampled; d_rvalid pulses one cycle; mem_write returns to 0.
4. Misalignment: d_size=11 with d_addr=0x13, and if_addr=0x6: each gets gnt and err in the same cycle; mem_write stays 0; mem_address is unchanged.
5. Store word with mem_done held low: d_err pulses exactly WRITE_TIMEOUT+1 cycles after d_gnt; mem_write returns to 0; state is IDLE.
6. rst asserted during READ_WAIT: all outputs are 0 asynchronously; no if_rvalid afterwards; after release, a new if_req is served normally.
